// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode constants and
// the helpers used to size and fill a frame.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Integer baud divider; truncation is intentional, the caller keeps it >= 2.
    function automatic int calc_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Even parity is the plain XOR of the byte; odd parity is its inverse.
    function automatic logic calc_parity(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled, held at zero by
// clear. bit_tick marks the last cycle of a bit period, bit_pre_tick the
// cycle before it (lets a caller register a pulse aligned with bit_tick).
module uart_baud_gen #(
    parameter int BAUD_DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick,
    output logic bit_pre_tick
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] cnt_reg;

    // Free-running period counter, wraps at the bit boundary, cleared on demand.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bit_tick     = (cnt_reg == CNT_LAST);
    assign bit_pre_tick = (cnt_reg == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity and
// 1 or 2 stop bits. Takes one byte per frame from the TX buffer and pulses
// tx_done in the final cycle of the last stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DATA_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_de,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_done,
    output logic       tx_busy
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD_RATE);

    uart_state_t state_reg;
    logic [7:0]  shift_reg;
    logic [2:0]  bit_idx_reg;
    logic        stop_idx_reg;
    logic        parity_reg;
    logic        tx_reg;
    logic        tx_done_reg;
    logic        tx_busy_reg;

    logic        bit_tick;
    logic        bit_pre_tick;
    logic        baud_clear;
    logic        last_stop;

    // Counter only runs once the start bit is on the line, so every bit
    // period (start included) is a full BAUD_DIV cycles; state changes after
    // that always coincide with the counter wrapping to zero.
    assign baud_clear = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign last_stop  = (STOP_BITS == 1) || stop_idx_reg;

    uart_baud_gen #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_gen (
        .clk         (clk),
        .rst         (rst),
        .clear       (baud_clear),
        .bit_tick    (bit_tick),
        .bit_pre_tick(bit_pre_tick)
    );

    // Frame sequencer; all outputs are registered here so tx never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            shift_reg    <= '0;
            bit_idx_reg  <= '0;
            stop_idx_reg <= 1'b0;
            parity_reg   <= 1'b0;
            tx_reg       <= 1'b1;
            tx_done_reg  <= 1'b0;
            tx_busy_reg  <= 1'b0;
        end else begin
            tx_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (tx_de) begin
                        tx_busy_reg <= 1'b1;
                        if (DATA_LAT == 0) begin
                            shift_reg  <= tx_data;
                            parity_reg <= calc_parity(tx_data, PARITY);
                            tx_reg     <= 1'b0;
                            state_reg  <= ST_START;
                        end else begin
                            state_reg <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Buffer's FIFO read data is valid in this cycle.
                    shift_reg  <= tx_data;
                    parity_reg <= calc_parity(tx_data, PARITY);
                    tx_reg     <= 1'b0;
                    state_reg  <= ST_START;
                end
                ST_START: begin
                    if (bit_tick) begin
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= '0;
                        state_reg   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (bit_idx_reg == 3'd7) begin
                            if (PARITY != PARITY_NONE) begin
                                tx_reg    <= parity_reg;
                                state_reg <= ST_PARITY;
                            end else begin
                                tx_reg       <= 1'b1;
                                stop_idx_reg <= 1'b0;
                                state_reg    <= ST_STOP;
                            end
                        end else begin
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                            bit_idx_reg <= bit_idx_reg + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        tx_reg       <= 1'b1;
                        stop_idx_reg <= 1'b0;
                        state_reg    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Registered one cycle early so the pulse lands on the final stop cycle.
                    if (last_stop && bit_pre_tick) begin
                        tx_done_reg <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (last_stop) begin
                            tx_busy_reg <= 1'b0;
                            state_reg   <= ST_IDLE;
                        end else begin
                            stop_idx_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    tx_reg      <= 1'b1;
                    tx_busy_reg <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_reg;
    assign tx_done = tx_done_reg;
    assign tx_busy = tx_busy_reg;

endmodule
